// File: rtl/screensaver_pkg.sv
// Shared definitions for the screensaver sprite motion logic.
//   - Default screen geometry.
//   - Position and arithmetic widths. Arithmetic is one bit wider than a
//     position so that pos+step cannot wrap.
//   - Direction and FSM state enums.
//   - Mapping from the 2-bit speed select to a per-frame pixel step.
package screensaver_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int POS_W        = 10;
  localparam int CALC_W       = 11;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_X = 2'd1,
    STEP_Y = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // 0 -> 1 px, 1 -> 2 px, 2 -> 4 px, 3 -> 8 px per frame
  function automatic logic [CALC_W-1:0] speed_to_step(input logic [1:0] speed);
    logic [CALC_W-1:0] step;
    case (speed)
      2'd0:    step = CALC_W'(1);
      2'd1:    step = CALC_W'(2);
      2'd2:    step = CALC_W'(4);
      default: step = CALC_W'(8);
    endcase
    return step;
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// Combinational one-axis motion step with edge bounce.
//   pos      : current position, kept in [0, MAX]
//   dir      : current direction of travel
//   step     : pixels to move this frame
//   pos_next : position after the step, clamped to the edges
//   dir_next : direction after the step; it reverses on a bounce
//   bounce   : 1 when this step reached an edge
module bounce_axis
  import screensaver_pkg::*;
#(
  parameter int MAX = 576
) (
  input  logic [POS_W-1:0]  pos,
  input  dir_t              dir,
  input  logic [CALC_W-1:0] step,
  output logic [POS_W-1:0]  pos_next,
  output dir_t              dir_next,
  output logic              bounce
);

  localparam logic [CALC_W-1:0] MAX_C = CALC_W'(MAX);

  logic [CALC_W-1:0] pos_c;
  logic [CALC_W-1:0] sum;
  logic [CALC_W-1:0] diff;

  assign pos_c = {1'b0, pos};
  assign sum   = pos_c + step;
  assign diff  = pos_c - step;

  always_comb begin
    pos_next = pos;
    dir_next = dir;
    bounce   = 1'b0;
    if (dir == DIR_POS) begin
      // Landing exactly on the edge also counts as a bounce.
      if (sum >= MAX_C) begin
        pos_next = MAX_C[POS_W-1:0];
        dir_next = DIR_NEG;
        bounce   = 1'b1;
      end else begin
        pos_next = sum[POS_W-1:0];
      end
    end else begin
      if (pos_c <= step) begin
        pos_next = '0;
        dir_next = DIR_POS;
        bounce   = 1'b1;
      end else begin
        pos_next = diff[POS_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bounce_controller.sv
// Per-frame motion scheduler for the screensaver sprite.
// On an accepted frame_start_i the block steps x, then y, then commits both
// positions and the palette together. The committed outputs therefore change
// only once per frame, during vertical blanking.
//   clk_25_175    : pixel clock
//   rst           : synchronous active-high reset
//   frame_start_i : one-cycle pulse at the start of vertical blanking
//   pause_btn_i   : pause button level; each rising edge toggles paused_o
//   speed_i       : step select, 1/2/4/8 px per frame
//   x_o, y_o      : committed sprite top-left position
//   palette_o     : palette index; advances once per frame that bounced
//   paused_o      : motion frozen
//   update_o      : one-cycle pulse when new outputs are committed
//   corner_o      : one-cycle pulse with update_o when both axes bounced
//   state_o       : current FSM state, for debug
// Handshake: there is no back-pressure. update_o is a one-cycle valid
// strobe, and x_o/y_o/palette_o/corner_o are meaningful in the cycle it is
// high. x_o/y_o/palette_o then hold until the next update_o.
module bounce_controller
  import screensaver_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 0,
  parameter int PAL_W    = 3
) (
  input  logic             clk_25_175,
  input  logic             rst,
  input  logic             frame_start_i,
  input  logic             pause_btn_i,
  input  logic [1:0]       speed_i,
  output logic [POS_W-1:0] x_o,
  output logic [POS_W-1:0] y_o,
  output logic [PAL_W-1:0] palette_o,
  output logic             paused_o,
  output logic             update_o,
  output logic             corner_o,
  output state_t           state_o
);

  localparam int XMAX = SCREEN_W - IMG_W;
  localparam int YMAX = SCREEN_H - IMG_H;

  state_t            state;
  state_t            state_next;
  logic              start_ok;
  logic              pause_q;
  logic [CALC_W-1:0] step_q;
  logic [POS_W-1:0]  x_s;
  logic [POS_W-1:0]  y_s;
  dir_t              dir_x;
  dir_t              dir_y;
  logic              bounce_x;
  logic              bounce_y;
  logic [POS_W-1:0]  x_calc;
  logic [POS_W-1:0]  y_calc;
  dir_t              dir_x_calc;
  dir_t              dir_y_calc;
  logic              bounce_x_calc;
  logic              bounce_y_calc;

  assign state_o  = state;
  assign start_ok = frame_start_i && !paused_o;

  bounce_axis #(.MAX(XMAX)) u_axis_x (
    .pos      (x_s),
    .dir      (dir_x),
    .step     (step_q),
    .pos_next (x_calc),
    .dir_next (dir_x_calc),
    .bounce   (bounce_x_calc)
  );

  bounce_axis #(.MAX(YMAX)) u_axis_y (
    .pos      (y_s),
    .dir      (dir_y),
    .step     (step_q),
    .pos_next (y_calc),
    .dir_next (dir_y_calc),
    .bounce   (bounce_y_calc)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = STEP_X;
      STEP_X:  state_next = STEP_Y;
      STEP_Y:  state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_25_175) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk_25_175) begin
    if (rst) begin
      pause_q   <= 1'b0;
      paused_o  <= 1'b0;
      step_q    <= CALC_W'(1);
      x_s       <= POS_W'(X_INIT);
      y_s       <= POS_W'(Y_INIT);
      dir_x     <= DIR_POS;
      dir_y     <= DIR_POS;
      bounce_x  <= 1'b0;
      bounce_y  <= 1'b0;
      x_o       <= POS_W'(X_INIT);
      y_o       <= POS_W'(Y_INIT);
      palette_o <= '0;
      update_o  <= 1'b0;
      corner_o  <= 1'b0;
    end else begin
      // Pause toggles in any state; an in-flight update still completes.
      pause_q  <= pause_btn_i;
      paused_o <= paused_o ^ (pause_btn_i & ~pause_q);
      update_o <= 1'b0;
      corner_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) step_q <= speed_to_step(speed_i);
        end
        STEP_X: begin
          x_s      <= x_calc;
          dir_x    <= dir_x_calc;
          bounce_x <= bounce_x_calc;
        end
        STEP_Y: begin
          y_s      <= y_calc;
          dir_y    <= dir_y_calc;
          bounce_y <= bounce_y_calc;
        end
        COMMIT: begin
          x_o <= x_s;
          y_o <= y_s;
          // A corner bounces both axes but advances the palette only once.
          if (bounce_x || bounce_y) palette_o <= palette_o + PAL_W'(1);
          update_o <= 1'b1;
          corner_o <= bounce_x & bounce_y;
        end
        default: ;
      endcase
    end
  end

endmodule
